// File: rtl/seven_segment_pkg.sv
// Shared segment patterns and the nibble decoder used by the seven-segment scan driver.
// Patterns are {a,b,c,d,e,f,g}, active-high; polarity is applied only at the pins.
package seven_segment_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Values 10-15 only light up when the hex glyphs are enabled.
  function automatic logic [6:0] seg_decode(input logic [3:0] value, input logic hex_en);
    logic [6:0] pat;
    pat = SEG_BLANK;
    case (value)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      4'd10:   pat = hex_en ? SEG_A : SEG_BLANK;
      4'd11:   pat = hex_en ? SEG_B : SEG_BLANK;
      4'd12:   pat = hex_en ? SEG_C : SEG_BLANK;
      4'd13:   pat = hex_en ? SEG_D : SEG_BLANK;
      4'd14:   pat = hex_en ? SEG_E : SEG_BLANK;
      4'd15:   pat = hex_en ? SEG_F : SEG_BLANK;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seven_segment_decode.sv
// Combinational nibble-to-segment decoder for the currently scanned digit.
module seven_segment_decode
  import seven_segment_pkg::*;
#(
  parameter int HEX_EN = 0
) (
  input  logic [3:0] value,
  output logic [6:0] pattern
);

  // Pure table lookup; no state.
  always_comb begin
    pattern = seg_decode(value, (HEX_EN != 0));
  end

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed N-digit seven-segment driver with dead time, leading-zero
// blanking, per-digit blink and decimal points; all pin outputs are registered.
module seven_segment_scan
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 0,
  parameter int HEX_EN       = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_tick
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
  localparam logic             POL      = (ACTIVE_LOW != 0);

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [FRM_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;

  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    div_wrap_s;
  logic                    frame_end_s;
  logic                    zero_run_s;
  logic [NUM_DIGITS-1:0]   lz_zero_s;
  logic [3:0]              cur_digit_s;
  logic                    cur_dp_s;
  logic                    cur_lz_s;
  logic                    cur_mask_s;
  logic [NUM_DIGITS-1:0]   onehot_s;
  logic [6:0]              cur_pattern_s;
  logic                    blank_s;
  logic                    blink_off_s;
  logic [6:0]              seg_act_s;
  logic                    dp_act_s;
  logic [NUM_DIGITS-1:0]   en_act_s;

  // Slot divider, digit index, frame counter and blink phase.
  always_comb begin
    div_wrap_s    = (div_cnt_q == DIV_LAST);
    frame_end_s   = div_wrap_s && (idx_q == IDX_LAST);
    div_cnt_d     = div_cnt_q;
    idx_d         = idx_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (div_wrap_s) begin
      div_cnt_d = {DIV_W{1'b0}};
      if (idx_q == IDX_LAST) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
    if (frame_end_s) begin
      if (frame_cnt_q == FRM_LAST) begin
        frame_cnt_d   = {FRM_W{1'b0}};
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FRM_W'(1);
      end
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Shadow capture: the display never looks at the live digit bus.
  always_comb begin
    sh_digits_d = sh_digits_q;
    sh_dp_d     = sh_dp_q;
    if (load) begin
      sh_digits_d = digits;
      sh_dp_d     = dp_in;
    end else begin
      sh_digits_d = sh_digits_q;
      sh_dp_d     = sh_dp_q;
    end
  end

  // lz_zero_s[i]: every shadow digit from the top down to i is zero.
  always_comb begin
    zero_run_s = 1'b1;
    lz_zero_s  = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run_s   = zero_run_s & (sh_digits_q[4*i +: 4] == 4'd0);
      lz_zero_s[i] = zero_run_s;
    end
  end

  // Per-digit mux onto the single shared decoder.
  always_comb begin
    cur_digit_s = 4'd0;
    cur_dp_s    = 1'b0;
    cur_lz_s    = 1'b0;
    cur_mask_s  = 1'b0;
    onehot_s    = {NUM_DIGITS{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit_s = sh_digits_q[4*i +: 4];
        cur_dp_s    = sh_dp_q[i];
        cur_lz_s    = lz_zero_s[i] && (i != 0);
        cur_mask_s  = blink_mask[i];
        onehot_s[i] = 1'b1;
      end else begin
        onehot_s[i] = 1'b0;
      end
    end
  end

  seven_segment_decode #(
    .HEX_EN (HEX_EN)
  ) u_decode (
    .value   (cur_digit_s),
    .pattern (cur_pattern_s)
  );

  // Blanking/blink override, dead-time gating, then pin polarity.
  always_comb begin
    blank_s     = blank_lz && cur_lz_s;
    blink_off_s = blink_en && cur_mask_s && blink_phase_q;
    if (blank_s || blink_off_s) begin
      seg_act_s = SEG_BLANK;
      dp_act_s  = 1'b0;
    end else begin
      seg_act_s = cur_pattern_s;
      dp_act_s  = cur_dp_s;
    end
    if (div_cnt_q == {DIV_W{1'b0}}) begin
      en_act_s = {NUM_DIGITS{1'b0}};
    end else begin
      en_act_s = onehot_s;
    end
    seg_d        = seg_act_s ^ {7{POL}};
    dp_d         = dp_act_s ^ POL;
    digit_en_d   = en_act_s ^ {NUM_DIGITS{POL}};
    frame_tick_d = frame_end_s;
  end

  // Counter and shadow state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q     <= {DIV_W{1'b0}};
      idx_q         <= {IDX_W{1'b0}};
      frame_cnt_q   <= {FRM_W{1'b0}};
      blink_phase_q <= 1'b0;
      sh_digits_q   <= {(4*NUM_DIGITS){1'b0}};
      sh_dp_q       <= {NUM_DIGITS{1'b0}};
    end else begin
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      sh_digits_q   <= sh_digits_d;
      sh_dp_q       <= sh_dp_d;
    end
  end

  // Pin registers; reset drives them to the inactive level of the panel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q        <= {7{POL}};
      dp_q         <= POL;
      digit_en_q   <= {NUM_DIGITS{POL}};
      frame_tick_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      digit_en_q   <= digit_en_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_en   = digit_en_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Self-checking bench: a cycle scoreboard fed from an absolute-time model plus
// directed per-frame checks, across plain, hex and active-low instances.
module tb_seven_segment_scan;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FL = SD * ND;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic [3:0]  blink_mask = 4'b0000;

  logic [6:0] seg_b, seg_h, seg_l;
  logic       dp_b, dp_h, dp_l;
  logic [3:0] en_b, en_h, en_l;
  logic       tick_b, tick_h, tick_l;

  seven_segment_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .ACTIVE_LOW(0), .HEX_EN(0)) dut (
    .clk(clk), .reset_n(reset_n), .digits(digits), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .blink_en(blink_en), .blink_mask(blink_mask),
    .seg(seg_b), .dp(dp_b), .digit_en(en_b), .frame_tick(tick_b));

  seven_segment_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .ACTIVE_LOW(0), .HEX_EN(1)) dut_hex (
    .clk(clk), .reset_n(reset_n), .digits(digits), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .blink_en(blink_en), .blink_mask(blink_mask),
    .seg(seg_h), .dp(dp_h), .digit_en(en_h), .frame_tick(tick_h));

  seven_segment_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .ACTIVE_LOW(1), .HEX_EN(0)) dut_al (
    .clk(clk), .reset_n(reset_n), .digits(digits), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .blink_en(blink_en), .blink_mask(blink_mask),
    .seg(seg_l), .dp(dp_l), .digit_en(en_l), .frame_tick(tick_l));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s got %h want %h at %0t", tag, obs, want, $time);
    end
  endtask

  function automatic logic [6:0] ref_pattern(input logic [3:0] v, input bit hex);
    logic [6:0] p;
    case (v)
      4'd0:    p = 7'b1111110;
      4'd1:    p = 7'b0110000;
      4'd2:    p = 7'b1101101;
      4'd3:    p = 7'b1111001;
      4'd4:    p = 7'b0110011;
      4'd5:    p = 7'b1011011;
      4'd6:    p = 7'b1011111;
      4'd7:    p = 7'b1110000;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1111011;
      4'd10:   p = hex ? 7'b1110111 : 7'b0000000;
      4'd11:   p = hex ? 7'b0011111 : 7'b0000000;
      4'd12:   p = hex ? 7'b1001110 : 7'b0000000;
      4'd13:   p = hex ? 7'b0111101 : 7'b0000000;
      4'd14:   p = hex ? 7'b1001111 : 7'b0000000;
      4'd15:   p = hex ? 7'b1000111 : 7'b0000000;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  typedef struct {
    logic [6:0] seg_dec;
    logic [6:0] seg_hex;
    logic       dp;
    logic [3:0] en;
    logic       tick;
  } exp_t;

  exp_t        sb_q[$];
  int          m_t;
  logic [15:0] m_sh;
  logic [3:0]  m_dp;

  // Model: output registered at each edge, derived from cycles since reset release.
  always begin
    exp_t e;
    int   idx, dv, frm;
    bit   off;
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_t = 0;
      m_sh = 16'h0000;
      m_dp = 4'b0000;
      e.seg_dec = 7'd0; e.seg_hex = 7'd0; e.dp = 1'b0; e.en = 4'd0; e.tick = 1'b0;
      sb_q.delete();
      sb_q.push_back(e);
    end else begin
      dv  = m_t % SD;
      idx = (m_t / SD) % ND;
      frm = m_t / FL;
      off = (blank_lz && idx > 0 && (m_sh >> (4 * idx)) == 16'd0) ||
            (blink_en && blink_mask[idx] && ((frm / BF) % 2 == 1));
      e.seg_dec = off ? 7'd0 : ref_pattern(m_sh[4*idx +: 4], 1'b0);
      e.seg_hex = off ? 7'd0 : ref_pattern(m_sh[4*idx +: 4], 1'b1);
      e.dp      = !off && m_dp[idx];
      e.en      = (dv == 0) ? 4'd0 : 4'(1 << idx);
      e.tick    = (m_t % FL) == FL - 1;
      sb_q.push_back(e);
      m_t++;
      if (load) begin
        m_sh = digits;
        m_dp = dp_in;
      end
    end
  end

  // Monitor: pop one expectation per cycle, compare away from the active edge.
  always begin
    exp_t e;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_eq("sb_base", 32'({seg_b, dp_b, en_b, tick_b}), 32'({e.seg_dec, e.dp, e.en, e.tick}));
      chk_eq("sb_hex",  32'({seg_h, dp_h, en_h, tick_h}), 32'({e.seg_hex, e.dp, e.en, e.tick}));
      chk_eq("sb_alow", 32'({seg_l, dp_l, en_l, tick_l}), 32'({~e.seg_dec, ~e.dp, ~e.en, e.tick}));
    end
  end

  logic [6:0] cap_b[4], cap_h[4], cap_l[4];
  logic       cap_dp[4];
  logic [3:0] cap_en[4], cap_len[4];
  int         tick_cnt, tick_pos;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mid-slot reset, check pins immediately, then release and load; returns at frame start.
  task automatic reset_and_load(input logic [15:0] d, input logic [3:0] p);
    step();
    reset_n = 1'b0;
    #2;
    chk_eq("rst_now_base", 32'({seg_b, dp_b, en_b, tick_b}), 32'(13'd0));
    chk_eq("rst_now_alow", 32'({seg_l, dp_l, en_l, tick_l}), 32'({7'h7f, 1'b1, 4'hf, 1'b0}));
    step();
    step();
    reset_n = 1'b1;
    digits = d;
    dp_in = p;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Sample the last active cycle of each slot over one frame.
  task automatic capture_frame();
    tick_cnt = 0;
    tick_pos = -1;
    for (int j = 0; j < FL; j++) begin
      @(negedge clk);
      if (j % SD == SD - 1) begin
        cap_b[j/SD]   = seg_b;
        cap_h[j/SD]   = seg_h;
        cap_l[j/SD]   = seg_l;
        cap_dp[j/SD]  = dp_b;
        cap_en[j/SD]  = en_b;
        cap_len[j/SD] = en_l;
      end
      if (tick_b) begin
        tick_cnt++;
        tick_pos = j;
      end
    end
  endtask

  logic [6:0] exp_1234[4];
  logic [6:0] exp_abcf[4];

  initial begin
    exp_1234[0] = 7'b0110011; exp_1234[1] = 7'b1111001;
    exp_1234[2] = 7'b1101101; exp_1234[3] = 7'b0110000;
    exp_abcf[0] = 7'b1000111; exp_abcf[1] = 7'b1001110;
    exp_abcf[2] = 7'b0011111; exp_abcf[3] = 7'b1110111;

    // Reset and basic scan of 1234.
    reset_and_load(16'h1234, 4'b0000);
    for (int j = 0; j < FL; j++) begin
      @(negedge clk);
      chk_eq("scan_en", 32'(en_b), (j % SD == 0) ? 32'd0 : 32'(1 << (j / SD)));
      if (j % SD != 0) begin
        chk_eq("scan_seg", 32'(seg_b), 32'(exp_1234[j/SD]));
      end
    end
    capture_frame();
    chk_eq("tick_count", 32'(tick_cnt), 32'd1);
    chk_eq("tick_pos", 32'(tick_pos), 32'(FL - 1));
    chk_eq("slot0_en", 32'(cap_en[0]), 32'd1);
    chk_eq("slot3_en", 32'(cap_en[3]), 32'd8);

    // Mid-slot load lands two cycles later in the same slot.
    reset_and_load(16'h1234, 4'b0000);
    step();
    digits = 16'h1239;
    load = 1'b1;
    step();
    load = 1'b0;
    @(negedge clk);
    chk_eq("midload_old", 32'({seg_b, en_b}), 32'({7'b0110011, 4'b0001}));
    @(negedge clk);
    chk_eq("midload_new", 32'({seg_b, en_b}), 32'({7'b1111011, 4'b0001}));
    capture_frame();

    // Leading-zero blanking, dp suppressed on blanked digits.
    blank_lz = 1'b1;
    reset_and_load(16'h0070, 4'b1111);
    capture_frame();
    chk_eq("lz_d0", 32'(cap_b[0]), 32'(7'b1111110));
    chk_eq("lz_d1", 32'(cap_b[1]), 32'(7'b1110000));
    chk_eq("lz_d2", 32'(cap_b[2]), 32'd0);
    chk_eq("lz_d3", 32'(cap_b[3]), 32'd0);
    chk_eq("lz_dp", 32'({cap_dp[3], cap_dp[2], cap_dp[1], cap_dp[0]}), 32'(4'b0011));
    reset_and_load(16'h0000, 4'b0000);
    capture_frame();
    chk_eq("lz0_d0", 32'(cap_b[0]), 32'(7'b1111110));
    chk_eq("lz0_rest", 32'({cap_b[3], cap_b[2], cap_b[1]}), 32'd0);
    blank_lz = 1'b0;

    // Hex glyphs on the hex instance, blanks on the decimal one.
    reset_and_load(16'hABCF, 4'b0000);
    capture_frame();
    for (int i = 0; i < ND; i++) begin
      chk_eq("hex_on", 32'(cap_h[i]), 32'(exp_abcf[i]));
      chk_eq("hex_off", 32'(cap_b[i]), 32'd0);
    end

    // Active-low pins.
    reset_and_load(16'h0008, 4'b0000);
    capture_frame();
    chk_eq("alow_seg8", 32'(cap_l[0]), 32'd0);
    chk_eq("alow_en0", 32'(cap_len[0]), 32'(4'b1110));
    chk_eq("alow_seg0", 32'(cap_l[1]), 32'(7'b0000001));

    // Blink digit 1: two frames on, two frames off.
    blink_en = 1'b1;
    blink_mask = 4'b0010;
    reset_and_load(16'h4321, 4'b0010);
    for (int f = 0; f < 7; f++) begin
      capture_frame();
      if ((f / BF) % 2 == 1) begin
        chk_eq("blink_off_seg", 32'({cap_b[1], cap_dp[1]}), 32'd0);
      end else begin
        chk_eq("blink_on_seg", 32'({cap_b[1], cap_dp[1]}), 32'({7'b1101101, 1'b1}));
      end
      chk_eq("blink_other", 32'({cap_b[0], cap_dp[0]}), 32'({7'b0110000, 1'b0}));
    end
    blink_en = 1'b0;
    capture_frame();
    chk_eq("blink_release", 32'({cap_b[1], cap_dp[1]}), 32'({7'b1101101, 1'b1}));

    step();
    step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
